// File: rtl/mempat_pkg.sv
// +----------------------------------------------------------------------------+
// | mempat_pkg                                                                 |
// | Shared types and constants for the memory pattern generator.               |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package mempat_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GEN   = 2'd1,
      SHOW  = 2'd2,
      READY = 2'd3
   } state_t;

   localparam int N_L1 = 9;
   localparam int N_L2 = 16;
   localparam int N_L3 = 25;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

   function automatic logic [1:0] level_sat(input logic [1:0] lvl);
      return (lvl == 2'd0) ? 2'd1 : lvl;
   endfunction

endpackage

`default_nettype wire

// File: rtl/memory_pattern_gen_lfsr16.sv
// +----------------------------------------------------------------------------+
// | lfsr16                                                                     |
// | 16-bit Fibonacci LFSR, shifts every cycle, optional synchronous reload.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module lfsr16
   import mempat_pkg::*;
#(
   parameter logic [15:0] RESET_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   logic w_fb;

   assign w_fb = ^(q & LFSR_TAP_MASK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RESET_SEED;
      end else if (load) begin
         q <= seed;
      end else begin
         q <= {q[14:0], w_fb};
      end
   end

endmodule

`default_nettype wire

// File: rtl/memory_pattern_gen.sv
// +----------------------------------------------------------------------------+
// | memory_pattern_gen                                                         |
// | Builds a random lit-cell pattern per level, shows it for SHOW_CYCLES.      |
// | Build option: MEMPAT_FIXED_SEED_EN reloads the LFSR seed on each start.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module memory_pattern_gen
   import mempat_pkg::*;
#(
   parameter int          SHOW_CYCLES = 200_000_000,
   parameter int          K_L1        = 3,
   parameter int          K_L2        = 5,
   parameter int          K_L3        = 7,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        clear,
   input  logic [1:0]  o_level,
   output logic [8:0]  seq1,
   output logic [15:0] seq2,
   output logic [24:0] seq3,
   output logic        display,
   output logic        busy,
   output logic        done
);

   localparam int TIMER_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] C_TIMER_LOAD = TIMER_W'(SHOW_CYCLES - 1);

   state_t               r_state;
   logic [1:0]           r_lvl;
   logic [4:0]           r_cnt;
   logic [TIMER_W-1:0]   r_timer;

   logic [15:0] w_lfsr;
   logic        w_lfsr_load;
   logic        w_lfsr_unused;
   logic [4:0]  w_cand;
   logic [4:0]  w_n;
   logic [4:0]  w_k;
   logic [24:0] w_onehot;
   logic [24:0] w_cur;
   logic        w_take;
   logic        w_last;
   logic        w_start_ok;

   assign w_start_ok = start && !clear && ((r_state == IDLE) || (r_state == READY));

`ifdef MEMPAT_FIXED_SEED_EN
   assign w_lfsr_load = w_start_ok;
`else
   assign w_lfsr_load = 1'b0;
`endif

   lfsr16 #(
      .RESET_SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (w_lfsr_load),
      .seed  (LFSR_SEED),
      .q     (w_lfsr)
   );

   assign w_cand        = w_lfsr[4:0];
   assign w_lfsr_unused = ^w_lfsr[15:5];
   assign w_onehot      = 25'd1 << w_cand;

   always_comb begin
      w_n   = 5'(N_L1);
      w_k   = 5'(K_L1);
      w_cur = {16'd0, seq1};
      case (r_lvl)
         2'd2: begin
            w_n   = 5'(N_L2);
            w_k   = 5'(K_L2);
            w_cur = {9'd0, seq2};
         end
         2'd3: begin
            w_n   = 5'(N_L3);
            w_k   = 5'(K_L3);
            w_cur = seq3;
         end
         default: ;
      endcase
   end

   // A candidate is taken only if it lands inside the grid on an unlit cell
   assign w_take = (w_cand < w_n) && ((w_cur & w_onehot) == 25'd0);
   assign w_last = (5'(r_cnt + 5'd1) == w_k);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_lvl   <= 2'd1;
         r_cnt   <= 5'd0;
         r_timer <= '0;
         seq1    <= '0;
         seq2    <= '0;
         seq3    <= '0;
         display <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (clear) begin
            r_state <= IDLE;
            r_cnt   <= 5'd0;
            r_timer <= '0;
            seq1    <= '0;
            seq2    <= '0;
            seq3    <= '0;
            display <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (r_state)
               IDLE, READY: begin
                  if (w_start_ok) begin
                     r_lvl   <= level_sat(o_level);
                     r_cnt   <= 5'd0;
                     seq1    <= '0;
                     seq2    <= '0;
                     seq3    <= '0;
                     r_state <= GEN;
                     busy    <= 1'b1;
                  end
               end
               GEN: begin
                  if (w_take) begin
                     case (r_lvl)
                        2'd2:    seq2 <= seq2 | w_onehot[15:0];
                        2'd3:    seq3 <= seq3 | w_onehot;
                        default: seq1 <= seq1 | w_onehot[8:0];
                     endcase
                     r_cnt <= 5'(r_cnt + 5'd1);
                     if (w_last) begin
                        r_timer <= C_TIMER_LOAD;
                        r_state <= SHOW;
                        display <= 1'b1;
                     end
                  end
               end
               SHOW: begin
                  if (r_timer == '0) begin
                     r_state <= READY;
                     display <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     r_timer <= r_timer - 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_memory_pattern_gen.sv
// +----------------------------------------------------------------------------+
// | tb_memory_pattern_gen                                                      |
// | Directed self-checking bench for memory_pattern_gen (SHOW_CYCLES = 20).    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_memory_pattern_gen;

   localparam int SHOW = 20;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        clear;
   logic [1:0]  o_level;
   logic [8:0]  seq1;
   logic [15:0] seq2;
   logic [24:0] seq3;
   logic        display;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   memory_pattern_gen #(
      .SHOW_CYCLES (SHOW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .clear   (clear),
      .o_level (o_level),
      .seq1    (seq1),
      .seq2    (seq2),
      .seq3    (seq3),
      .display (display),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference pattern for a round started with the LFSR freshly at 16'hACE1
   function automatic logic [24:0] model_pat(input int lvl);
      logic [15:0] l;
      logic [24:0] p;
      int n, k, cnt, c;
      l   = 16'hACE1;
      p   = '0;
      cnt = 0;
      n   = (lvl == 3) ? 25 : (lvl == 2) ? 16 : 9;
      k   = (lvl == 3) ? 7 : (lvl == 2) ? 5 : 3;
      for (int i = 0; i < 5000 && cnt < k; i++) begin
         c = int'(l[4:0]);
         if (c < n && !p[c]) begin
            p[c] = 1'b1;
            cnt++;
         end
         l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      end
      return p;
   endfunction

   task automatic kick(input logic [1:0] lvl);
      o_level = lvl;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic wait_show();
      int n;
      n = 0;
      while (!display && n < 300) begin
         tick();
         n++;
      end
      check("gen_reaches_show", 32'(n < 300), 32'd1);
   endtask

   task automatic finish_show(input bit poke);
      int hi;
      hi = 0;
      while (display && hi < 100) begin
         hi++;
         if (poke && hi == 5) start = 1'b1;
         tick();
         start = 1'b0;
      end
      check("display_len", 32'(hi), 32'(SHOW));
      check("done_on_fall", 32'(done), 32'd1);
      check("busy_in_ready", 32'(busy), 32'd0);
      tick();
      check("done_single", 32'(done), 32'd0);
   endtask

   initial begin
      logic [24:0] first_pat;
      bit          any_diff;
      int          dones;

      rst_n   = 1'b0;
      start   = 1'b0;
      clear   = 1'b0;
      o_level = 2'd1;
      repeat (3) tick();
      check("rst_display", 32'(display), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_seq", 32'({seq1, seq2} | 32'(seq3)), 32'd0);
      check("rst_lfsr", 32'(dut.u_lfsr.q), 32'h0000ACE1);
      rst_n = 1'b1;
      tick();

      // Level 1 round
      kick(2'd1);
      check("l1_busy", 32'(busy), 32'd1);
      wait_show();
      check("l1_pop", 32'($countones(seq1)), 32'd3);
      check("l1_seq2", 32'(seq2), 32'd0);
      check("l1_seq3", 32'(seq3), 32'd0);
`ifdef MEMPAT_FIXED_SEED_EN
      check("l1_model", 32'(seq1), 32'(model_pat(1)));
`endif
      first_pat = 25'(seq1);
      finish_show(1'b0);
      repeat (3) tick();
      check("l1_held", 32'(seq1), 32'(first_pat));

      // Level 0 saturates to 1
      kick(2'd0);
      wait_show();
      finish_show(1'b0);
      check("l0_pop", 32'($countones(seq1)), 32'd3);
      check("l0_others", 32'(seq2) | 32'(seq3), 32'd0);
`ifdef MEMPAT_FIXED_SEED_EN
      check("l0_model", 32'(seq1), 32'(model_pat(1)));
`endif

      // Level 2
      kick(2'd2);
      wait_show();
      finish_show(1'b0);
      check("l2_pop", 32'($countones(seq2)), 32'd5);
      check("l2_others", 32'(seq1) | 32'(seq3), 32'd0);
`ifdef MEMPAT_FIXED_SEED_EN
      check("l2_model", 32'(seq2), 32'(model_pat(2)));
`endif

      // Level 3
      kick(2'd3);
      wait_show();
      finish_show(1'b0);
      check("l3_pop", 32'($countones(seq3)), 32'd7);
      check("l3_others", 32'(seq1) | 32'(seq2), 32'd0);
`ifdef MEMPAT_FIXED_SEED_EN
      check("l3_model", 32'(seq3), 32'(model_pat(3)));
`endif

      // Repeatability of level-3 rounds
      first_pat = seq3;
      any_diff  = 1'b0;
      for (int r = 0; r < 8; r++) begin
         repeat (r + 1) tick();
         kick(2'd3);
         wait_show();
         finish_show(1'b0);
         if (seq3 !== first_pat) any_diff = 1'b1;
      end
`ifdef MEMPAT_FIXED_SEED_EN
      check("fixed_seed_repeat", 32'(any_diff), 32'd0);
`else
      check("free_run_varies", 32'(any_diff), 32'd1);
`endif

      // Asynchronous reset in the middle of SHOW
      kick(2'd2);
      wait_show();
      repeat (5) tick();
      rst_n = 1'b0;
      #2;
      check("arst_display", 32'(display), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_seq2", 32'(seq2), 32'd0);
      check("arst_lfsr", 32'(dut.u_lfsr.q), 32'h0000ACE1);
      tick();
      rst_n = 1'b1;
      tick();
      check("arst_idle", 32'({busy, display, done}), 32'd0);

      // clear beats start during SHOW
      kick(2'd3);
      wait_show();
      repeat (3) tick();
      start = 1'b1;
      clear = 1'b1;
      tick();
      start = 1'b0;
      clear = 1'b0;
      check("clr_display", 32'(display), 32'd0);
      check("clr_busy", 32'(busy), 32'd0);
      check("clr_seq", 32'(seq1) | 32'(seq2) | 32'(seq3), 32'd0);
      dones = int'(done);
      for (int i = 0; i < 30; i++) begin
         tick();
         if (done) dones++;
      end
      check("clr_no_done", 32'(dones), 32'd0);
      check("clr_stays_idle", 32'(busy), 32'd0);

      // start ignored during GEN and mid-SHOW, level change ignored
      kick(2'd1);
      start   = 1'b1;
      o_level = 2'd3;
      tick();
      start   = 1'b0;
      wait_show();
      finish_show(1'b1);
      check("ign_pop", 32'($countones(seq1)), 32'd3);
      check("ign_seq3", 32'(seq3), 32'd0);
`ifdef MEMPAT_FIXED_SEED_EN
      check("ign_model", 32'(seq1), 32'(model_pat(1)));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
